// File: rtl/paper_pkg.sv
// Shared opcode and state definitions for the 2-bit paper processor sequencer.
package paper_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_INC = 2'b01;
    localparam logic [1:0] OP_JNO = 2'b10;
    localparam logic [1:0] OP_HLT = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } state_t;

endpackage

// File: rtl/paper_step_counter.sv
// Saturating retired-instruction counter; limit flags that the instruction
// retiring now is the last one the watchdog allows.
module paper_step_counter #(
    parameter int MAX_STEPS = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic step,
    output logic limit
);

    localparam int CNT_W = $clog2(MAX_STEPS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_STEPS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_STEPS - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (step && (count != MAX_CNT)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign limit = (count >= LAST_CNT);

endmodule

// File: rtl/paper_sequencer.sv
// Fetch/execute controller for the 2-bit paper processor: addresses the program
// RAM, executes NOP/INC/JNO/HLT against an accumulator and stops on HLT or watchdog.
module paper_sequencer #(
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = 2,
    parameter int MAX_STEPS = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] acc,
    output logic              status,
    output logic              halted,
    output logic              timeout,
    output logic              retire,
    output logic [1:0]        retire_op,
    output logic [ADDR_W-1:0] retire_pc
);

    import paper_pkg::*;

    state_t            state, state_d;
    logic [ADDR_W-1:0] pc, pc_d;
    logic [1:0]        ir, ir_d;
    logic [DATA_W-1:0] acc_d;
    logic              status_d, halted_d, timeout_d, retire_d;
    logic [1:0]        retire_op_d;
    logic [ADDR_W-1:0] retire_pc_d;

    logic [ADDR_W-1:0] pc_inc1, pc_inc2;
    logic [DATA_W-1:0] acc_inc;
    logic              inc_carry;
    logic              exec_step;
    logic              step_limit;

    assign pc_inc1 = pc + ADDR_W'(1);
    assign pc_inc2 = pc + ADDR_W'(2);
    assign {inc_carry, acc_inc} = {1'b0, acc} + (DATA_W + 1)'(1);

    paper_step_counter #(
        .MAX_STEPS (MAX_STEPS)
    ) u_step_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .step    (exec_step),
        .limit   (step_limit)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pc        <= '0;
            ir        <= OP_NOP;
            acc       <= '0;
            status    <= 1'b0;
            halted    <= 1'b0;
            timeout   <= 1'b0;
            retire    <= 1'b0;
            retire_op <= 2'b00;
            retire_pc <= '0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            ir        <= ir_d;
            acc       <= acc_d;
            status    <= status_d;
            halted    <= halted_d;
            timeout   <= timeout_d;
            retire    <= retire_d;
            retire_op <= retire_op_d;
            retire_pc <= retire_pc_d;
        end
    end

    // In EXEC the RAM is pointed at pc+1 so a JNO operand is already on mem_data.
    always_comb begin
        state_d     = state;
        pc_d        = pc;
        ir_d        = ir;
        acc_d       = acc;
        status_d    = status;
        halted_d    = halted;
        timeout_d   = timeout;
        retire_d    = 1'b0;
        retire_op_d = retire_op;
        retire_pc_d = retire_pc;
        exec_step   = 1'b0;
        mem_addr    = pc;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ir_d    = mem_data[1:0];
                state_d = EXEC;
            end
            EXEC: begin
                mem_addr    = pc_inc1;
                exec_step   = 1'b1;
                retire_d    = 1'b1;
                retire_op_d = ir;
                retire_pc_d = pc;
                state_d     = FETCH;
                case (ir)
                    OP_NOP: pc_d = pc_inc1;
                    OP_INC: begin
                        if (!status) begin
                            acc_d    = acc_inc;
                            status_d = inc_carry;
                        end
                        pc_d = pc_inc1;
                    end
                    OP_JNO: pc_d = status ? pc_inc2 : mem_data[ADDR_W-1:0];
                    default: begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end
                endcase
                // The watchdog still lets the last instruction take effect.
                if (step_limit && (ir != OP_HLT)) begin
                    state_d   = HALTED;
                    halted_d  = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_paper_sequencer.sv
// Table-driven bench for paper_sequencer: runs small programs from a RAM model and
// checks retire traces, halt timing, watchdog and reset/start handling.
module tb_paper_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mem_addr, mem_data, acc, retire_op, retire_pc;
    logic       status, halted, timeout, retire;

    logic [1:0] mem_addr9, mem_data9, acc9, retire_op9, retire_pc9;
    logic       status9, halted9, timeout9, retire9;

    logic [1:0] ram [4];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign mem_data  = ram[mem_addr];
    assign mem_data9 = ram[mem_addr9];

    paper_sequencer #(.ADDR_W(2), .DATA_W(2), .MAX_STEPS(16)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .acc       (acc),
        .status    (status),
        .halted    (halted),
        .timeout   (timeout),
        .retire    (retire),
        .retire_op (retire_op),
        .retire_pc (retire_pc)
    );

    // Second copy with a 9-step watchdog to pin down the limit boundary.
    paper_sequencer #(.ADDR_W(2), .DATA_W(2), .MAX_STEPS(9)) dut9 (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .mem_addr  (mem_addr9),
        .mem_data  (mem_data9),
        .acc       (acc9),
        .status    (status9),
        .halted    (halted9),
        .timeout   (timeout9),
        .retire    (retire9),
        .retire_op (retire_op9),
        .retire_pc (retire_pc9)
    );

    typedef struct {
        string       name;
        logic [7:0]  prog;
        bit          noisy_start;
        int          exp_retires;
        logic [31:0] exp_pcs;
        logic [31:0] exp_ops;
        int          exp_halt_edge;
        logic [1:0]  exp_acc;
        logic        exp_status;
        logic        exp_timeout;
        logic        exp_timeout9;
    } vec_t;

    vec_t vecs [6];

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic apply_stimulus(input vec_t v, input bit do_reset);
        int          n_ret;
        int          halt_edge;
        int          first_ret;
        logic [31:0] got_pcs;
        logic [31:0] got_ops;
        for (int i = 0; i < 4; i++) ram[i] = v.prog[2*i +: 2];
        if (do_reset) apply_reset();
        n_ret = 0;
        halt_edge = -1;
        first_ret = -1;
        got_pcs = '0;
        got_ops = '0;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = v.noisy_start;
        check_output({v.name, " fetch_addr"}, 32'(mem_addr), 32'd0);
        for (int e = 1; e <= 40; e++) begin
            @(posedge clock);
            #1;
            if (e == 1) check_output({v.name, " exec_addr"}, 32'(mem_addr), 32'd1);
            if (retire) begin
                if (first_ret < 0) first_ret = e;
                if (n_ret < 16) begin
                    got_pcs[2*n_ret +: 2] = retire_pc;
                    got_ops[2*n_ret +: 2] = retire_op;
                end
                n_ret++;
            end
            if (halted && halt_edge < 0) halt_edge = e;
        end
        start = 1'b0;
        check_output({v.name, " retires"}, 32'(n_ret), 32'(v.exp_retires));
        check_output({v.name, " first_retire_edge"}, 32'(first_ret), 32'd2);
        check_output({v.name, " halt_edge"}, 32'(halt_edge), 32'(v.exp_halt_edge));
        check_output({v.name, " retire_pcs"}, got_pcs, v.exp_pcs);
        check_output({v.name, " retire_ops"}, got_ops, v.exp_ops);
        check_output({v.name, " acc"}, 32'(acc), 32'(v.exp_acc));
        check_output({v.name, " status"}, 32'(status), 32'(v.exp_status));
        check_output({v.name, " halted"}, 32'(halted), 32'd1);
        check_output({v.name, " timeout"}, 32'(timeout), 32'(v.exp_timeout));
        check_output({v.name, " halted9"}, 32'(halted9), 32'd1);
        check_output({v.name, " timeout9"}, 32'(timeout9), 32'(v.exp_timeout9));
    endtask

    initial begin
        int idle_retires;
        int idle_halts;

        // Programs packed word0 in bits [1:0]; traces packed entry0 in bits [1:0].
        vecs[0] = '{"inc3_hlt",       8'hD5, 1'b0, 4,  32'h000000E4, 32'h000000D5, 8,  2'd3, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"inc3_hlt_noisy", 8'hD5, 1'b1, 4,  32'h000000E4, 32'h000000D5, 8,  2'd3, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{"inc_jno_loop",   8'hC9, 1'b0, 9,  32'h00034444, 32'h00039999, 18, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{"jno_self",       8'h02, 1'b0, 16, 32'h00000000, 32'hAAAAAAAA, 32, 2'd0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{"nop_wrap",       8'h00, 1'b0, 16, 32'hE4E4E4E4, 32'h00000000, 32, 2'd0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{"jno_fall_wrap",  8'h25, 1'b0, 16, 32'h24924924, 32'h65965965, 32, 2'd0, 1'b1, 1'b1, 1'b1};

        for (int i = 0; i < 4; i++) ram[i] = 2'b00;
        apply_reset();
        #1;
        check_output("reset acc", 32'(acc), 32'd0);
        check_output("reset status", 32'(status), 32'd0);
        check_output("reset halted", 32'(halted), 32'd0);
        check_output("reset timeout", 32'(timeout), 32'd0);
        check_output("reset retire", 32'(retire), 32'd0);
        check_output("reset retire_op", 32'(retire_op), 32'd0);
        check_output("reset retire_pc", 32'(retire_pc), 32'd0);
        check_output("reset mem_addr", 32'(mem_addr), 32'd0);

        for (int i = 0; i < 6; i++) apply_stimulus(vecs[i], 1'b1);

        // Asynchronous reset in the middle of the third EXEC of the INC program.
        for (int i = 0; i < 4; i++) ram[i] = vecs[0].prog[2*i +: 2];
        apply_reset();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check_output("mid_exec acc", 32'(acc), 32'd2);
        check_output("mid_exec mem_addr", 32'(mem_addr), 32'd3);
        check_output("mid_exec retire_pc", 32'(retire_pc), 32'd1);
        reset_n = 1'b0;
        #1;
        check_output("async acc", 32'(acc), 32'd0);
        check_output("async retire_pc", 32'(retire_pc), 32'd0);
        check_output("async retire_op", 32'(retire_op), 32'd0);
        check_output("async mem_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        idle_retires = 0;
        idle_halts = 0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clock);
            #1;
            if (retire) idle_retires++;
            if (halted) idle_halts++;
        end
        check_output("idle retires", 32'(idle_retires), 32'd0);
        check_output("idle halted", 32'(idle_halts), 32'd0);
        check_output("idle mem_addr", 32'(mem_addr), 32'd0);
        apply_stimulus(vecs[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
